// File: rtl/fd_inst_queue.sv
// Instruction queue between the byte-serial fetch unit and decode: an in-order
// circular buffer of completed instructions with valid/ready to decode and flush on redirect.
module fd_inst_queue #(
  parameter int DEPTH = 2  // legal values: 2 or 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        f_output,
  input  logic [47:0] f_inst,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_next_inst_pc,
  input  logic        f_mode,
  input  logic        flush,
  output logic        f_ready,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [47:0] d_inst,
  output logic [31:0] d_pc,
  output logic [31:0] d_next_pc,
  output logic        d_mode,
  output logic [2:0]  d_len,
  output logic [2:0]  d_count
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [2:0]    count;

  logic [47:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] npc_mem  [DEPTH];
  logic        mode_mem [DEPTH];
  logic [2:0]  len_mem  [DEPTH];

  logic       push;
  logic       pop;
  logic [2:0] push_len;

  // A full queue still accepts a push when decode frees the head in the same cycle.
  assign f_ready = (count < 3'(DEPTH)) | d_ready;
  assign d_valid = (count != 3'd0);
  assign push    = f_output & f_ready & ~flush;
  assign pop     = d_valid & d_ready;
  assign d_count = count;

  // Only the low three PC bits matter for a length of at most six bytes.
  assign push_len = f_mode ? (f_next_inst_pc[2:0] - f_pc[2:0]) : 3'd4;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 3'd0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
        npc_mem[i]  <= '0;
        mode_mem[i] <= 1'b0;
        len_mem[i]  <= 3'd0;
      end
    end else if (push) begin
      inst_mem[wr_ptr] <= f_inst;
      pc_mem[wr_ptr]   <= f_pc;
      npc_mem[wr_ptr]  <= f_next_inst_pc;
      mode_mem[wr_ptr] <= f_mode;
      len_mem[wr_ptr]  <= push_len;
    end
  end

  // Head fields read as zero whenever the queue is empty.
  always_comb begin
    d_inst    = '0;
    d_pc      = '0;
    d_next_pc = '0;
    d_mode    = 1'b0;
    d_len     = 3'd0;
    if (d_valid) begin
      d_inst    = inst_mem[rd_ptr];
      d_pc      = pc_mem[rd_ptr];
      d_next_pc = npc_mem[rd_ptr];
      d_mode    = mode_mem[rd_ptr];
      d_len     = len_mem[rd_ptr];
    end
  end

endmodule

// File: doc/fd_inst_queue.md
# fd_inst_queue

Instruction queue between the byte-serial fetch unit and the decode stage. It captures each completed instruction (up to 48 bits) together with its PC, fall-through PC, ISA mode and byte length. It presents the instructions to decode in order through a valid/ready handshake. When any later stage redirects the PC, it discards every wrong-path entry.

## Interface
- DEPTH, 2, number of entries; legal values 2 or 4 only.
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- f_output  in  1  fetch has a complete instruction this cycle (push request).
- f_inst  in  48  instruction bytes, byte 0 in [7:0], unused upper bytes zero.
- f_pc  in  32  address of the instruction's first byte.
- f_next_inst_pc  in  32  fall-through PC of the instruction.
- f_mode  in  1  ISA mode: 0 = fixed 4-byte, 1 = variable 1–6 byte.
- flush  in  1  OR of the m/d/t do_jmp redirects.
- f_ready  out  1  queue can accept a push this cycle.
- d_valid  out  1  head entry valid.
- d_ready  in  1  decode consumes the head this cycle.
- d_inst  out  48  head instruction.
- d_pc  out  32  head PC.
- d_next_pc  out  32  head fall-through PC.
- d_mode  out  1  head mode.
- d_len  out  3  head length in bytes.
- d_count  out  3  number of occupied entries, 0..DEPTH.

## Operation
- Storage is a circular buffer with read pointer, write pointer and count. Pointers wrap modulo DEPTH.
- Length computation: d_len = (f_next_inst_pc - f_pc)[2:0], computed at push time. Mode 0 always yields 4.
- push = f_output & f_ready & ~flush.
- pop = d_valid & d_ready.
- f_ready = (count < DEPTH) | d_ready. This is a combinational path from d_ready. Fetch must hold its completed instruction (no offset advance) while f_output & ~f_ready.
- Push only: the write slot is loaded, the write pointer advances, count increments.
- Pop only: the read pointer advances, count decrements. The vacated slot contents are don't-care.
- Push and pop in the same cycle: both pointers advance and count is unchanged. This is legal when full (the freed slot is written) and when count is 1.
- Flush: pointers and count clear to 0 at the next edge. Any same-cycle push is discarded. Any same-cycle pop completes (decode saw the head) but has no further effect.
- Output fields:
  - d_valid = (count != 0).
  - d_inst, d_pc, d_next_pc, d_mode and d_len read the slot at the read pointer. They are forced to zero when count == 0.
  - d_count = count.
- No push/pop bypass: an entry written at edge N is first visible at the head after edge N.

## Timing
- Reset (asynchronous, resetn low) clears:
  - count, both pointers and all slots to 0.
  - d_valid 0, all d_* data 0, d_count 0.
  - f_ready 1.
- Release of reset is synchronous to clk. The first push is accepted on the first rising edge with resetn high.
- Latency is 1 cycle: f_output high before edge N makes d_valid high after edge N.
- Throughput is one instruction per cycle in steady state when d_ready is held high.
- A reset asserted mid-operation empties the queue immediately, without waiting for a clock edge.
- Flush has priority over push. A flush with an empty queue is harmless.
- Count never exceeds DEPTH and never underflows. A pop with d_valid low is ignored.

## Test plan
- **Reset:** assert resetn=0 mid-stream with 2 entries held.
  - During reset: d_valid=0, d_count=0, f_ready=1, d_pc=0, all immediately.
  - After release, one push of f_pc=0x100 makes d_pc=0x100 one cycle later.
- **Single transfer:** push f_pc=0x40, f_next_inst_pc=0x44, f_mode=0, f_inst=0x8C010004 with d_ready=1.
  - Next cycle: d_valid=1, d_len=4, d_inst=0x8C010004, d_mode=0.
  - The following cycle: d_valid=0.
- **Fill (DEPTH=2):** d_ready=0, push mode-1 instructions at PC 0x10 (len 6, next 0x16) then 0x16 (len 1, next 0x17).
  - d_count=2 and f_ready=0.
  - A third f_output is not accepted until d_ready=1.
  - Head order is 0x10, then 0x16.
- **Full, simultaneous push/pop:** with 2 entries held, d_ready=1 and f_output=1 (PC 0x17).
  - f_ready=1 and d_count stays 2.
  - Heads on successive cycles: 0x16, then 0x17.
- **Flush with push:** 2 entries held, flush=1 and f_output=1 in the same cycle.
  - Next cycle: d_count=0, d_valid=0.
  - The pushed PC never appears at d_pc.
- **Wrap-around (DEPTH=4):** 10 pushes and pops with PCs 0x0, 0x4, …, 0x24 and random d_ready.
  - Pops emerge strictly in PC order.
  - No entry is lost or duplicated.
  - d_count stays within 0..4.
